// File: rtl/branch_predictor.sv
// BTB with per-entry saturating direction counters; lookup is combinational (0 cycles), training lands on the next edge.
// No backpressure: at most one resolved update per cycle, always accepted.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2,
    parameter int STAT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [XLEN-1:0]   pc_f,
    output logic              pred_taken_f,
    output logic [XLEN-1:0]   pred_target_f,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [XLEN-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [XLEN-1:0]   upd_pred_target,
    output logic              mispredict_e,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam logic [CNT_BITS-1:0] CTR_MAX = '1;
    localparam logic [CNT_BITS-1:0] CTR_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CTR_WNT = CTR_WT - CNT_BITS'(1);

    logic                valid_q [ENTRIES];
    logic [TAG_W-1:0]    tag_q   [ENTRIES];
    logic [XLEN-1:0]     tgt_q   [ENTRIES];
    logic [CNT_BITS-1:0] ctr_q   [ENTRIES];
    logic                jmp_q   [ENTRIES];

    logic [STAT_W-1:0]   br_q, br_d;
    logic [STAT_W-1:0]   mp_q, mp_d;

    logic [IDX-1:0]      idx_f, idx_u;
    logic [TAG_W-1:0]    tag_f, tag_u;
    logic                hit_f, hit_u;
    logic                train;

    logic                wr_en;
    logic [XLEN-1:0]     tgt_d;
    logic [CNT_BITS-1:0] ctr_d;
    logic                jmp_d;

    // pc[1:0] carries no information for aligned fetch
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{pc_f[1:0], upd_pc[1:0]};

    assign idx_f = pc_f[IDX+1:2];
    assign tag_f = pc_f[XLEN-1:IDX+2];
    assign idx_u = upd_pc[IDX+1:2];
    assign tag_u = upd_pc[XLEN-1:IDX+2];

    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_u = valid_q[idx_u] && (tag_q[idx_u] == tag_u);

    assign pred_taken_f  = enable && hit_f && (jmp_q[idx_f] || ctr_q[idx_f][CNT_BITS-1]);
    assign pred_target_f = pred_taken_f ? tgt_q[idx_f] : '0;

    assign mispredict_e = upd_valid &&
                          ((upd_taken != upd_pred_taken) ||
                           (upd_taken && (upd_target != upd_pred_target)));

    assign train = upd_valid && enable;

    always_comb begin
        wr_en = 1'b0;
        tgt_d = tgt_q[idx_u];
        ctr_d = ctr_q[idx_u];
        jmp_d = jmp_q[idx_u];
        if (train) begin
            if (hit_u) begin
                wr_en = 1'b1;
                if (upd_is_jump) begin
                    ctr_d = CTR_MAX;
                    jmp_d = 1'b1;
                end else if (upd_taken) begin
                    if (ctr_q[idx_u] != CTR_MAX) ctr_d = ctr_q[idx_u] + CNT_BITS'(1);
                end else begin
                    if (ctr_q[idx_u] != '0) ctr_d = ctr_q[idx_u] - CNT_BITS'(1);
                end
                if (upd_taken) tgt_d = upd_target;
            end else if (upd_taken) begin
                // Allocation replaces whatever aliased entry lived here
                wr_en = 1'b1;
                tgt_d = upd_target;
                jmp_d = upd_is_jump;
                ctr_d = upd_is_jump ? CTR_MAX : CTR_WT;
            end
        end
    end

    always_comb begin
        br_d = br_q;
        mp_d = mp_q;
        if (train) begin
            br_d = br_q + STAT_W'(1);
            if (mispredict_e) mp_d = mp_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= CTR_WNT;
                jmp_q[i]   <= 1'b0;
            end
            br_q <= '0;
            mp_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[idx_u] <= 1'b1;
                tag_q[idx_u]   <= tag_u;
                tgt_q[idx_u]   <= tgt_d;
                ctr_q[idx_u]   <= ctr_d;
                jmp_q[idx_u]   <= jmp_d;
            end
            br_q <= br_d;
            mp_q <= mp_d;
        end
    end

    assign stat_branches    = br_q;
    assign stat_mispredicts = mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: table of per-cycle vectors plus reset, stat and wrap sequences.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict_e;
    logic [7:0]  stat_branches;
    logic [7:0]  stat_mispredicts;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .XLEN(32), .ENTRIES(16), .CNT_BITS(2), .STAT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pc_f(pc_f),
        .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict_e(mispredict_e),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    typedef struct {
        logic        en;
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        uj;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        ept;
        logic [31:0] etgt;
        logic        emis;
        logic [7:0]  ebr;
        logic [7:0]  emp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic [31:0] pc,
                                input logic uv, input logic [31:0] upc, input logic uj,
                                input logic ut, input logic [31:0] utgt,
                                input logic upt, input logic [31:0] uptgt,
                                input logic ept, input logic [31:0] etgt, input logic emis,
                                input logic [7:0] ebr, input logic [7:0] emp);
        vec_t v;
        v.en = en; v.pc = pc; v.uv = uv; v.upc = upc; v.uj = uj; v.ut = ut;
        v.utgt = utgt; v.upt = upt; v.uptgt = uptgt; v.ept = ept; v.etgt = etgt;
        v.emis = emis; v.ebr = ebr; v.emp = emp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one update, check the combinational flag, let it land on the next edge
    task automatic do_upd(input logic [31:0] pc, input logic j, input logic t,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                          input logic emis);
        upd_valid = 1'b1; upd_pc = pc; upd_is_jump = j; upd_taken = t;
        upd_target = tgt; upd_pred_taken = pt; upd_pred_target = ptgt;
        #1;
        check("upd.mispredict", {31'd0, mispredict_e}, {31'd0, emis});
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; pc_f = 32'h100;
        upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        #1;
        check("rst.pred_taken", {31'd0, pred_taken_f}, 32'd0);
        check("rst.pred_target", pred_target_f, 32'd0);
        check("rst.branches", {24'd0, stat_branches}, 32'd0);
        check("rst.mispredicts", {24'd0, stat_mispredicts}, 32'd0);
        check("rst.mispredict", {31'd0, mispredict_e}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        //             en pc      uv upc     uj ut utgt    upt uptgt   ept etgt   mis br  mp
        vecs.push_back(mk(1, 'h100, 0, 'h0,   0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 0,  0));
        vecs.push_back(mk(1, 'h100, 1, 'h100, 0, 1, 'h40,  0, 'h0,   0, 'h0,   1, 0,  0));
        vecs.push_back(mk(1, 'h100, 0, 'h0,   0, 0, 'h0,   0, 'h0,   1, 'h40,  0, 1,  1));
        vecs.push_back(mk(1, 'h100, 1, 'h100, 0, 0, 'h0,   1, 'h40,  1, 'h40,  1, 1,  1));
        vecs.push_back(mk(1, 'h100, 1, 'h100, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 2,  2));
        vecs.push_back(mk(1, 'h100, 1, 'h100, 0, 1, 'h40,  0, 'h0,   0, 'h0,   1, 3,  2));
        vecs.push_back(mk(1, 'h100, 1, 'h100, 0, 1, 'h40,  0, 'h0,   0, 'h0,   1, 4,  3));
        vecs.push_back(mk(1, 'h100, 1, 'h100, 0, 1, 'h40,  1, 'h40,  1, 'h40,  0, 5,  4));
        vecs.push_back(mk(1, 'h100, 1, 'h100, 0, 1, 'h40,  1, 'h40,  1, 'h40,  0, 6,  4));
        vecs.push_back(mk(1, 'h100, 1, 'h100, 0, 0, 'h0,   1, 'h40,  1, 'h40,  1, 7,  4));
        vecs.push_back(mk(1, 'h100, 0, 'h0,   0, 0, 'h0,   0, 'h0,   1, 'h40,  0, 8,  5));
        vecs.push_back(mk(1, 'h204, 1, 'h204, 1, 1, 'h800, 0, 'h0,   0, 'h0,   1, 8,  5));
        vecs.push_back(mk(1, 'h204, 1, 'h204, 1, 1, 'h800, 1, 'h800, 1, 'h800, 0, 9,  6));
        vecs.push_back(mk(1, 'h100, 1, 'h100, 0, 1, 'h80,  1, 'h40,  1, 'h40,  1, 10, 6));
        vecs.push_back(mk(1, 'h100, 0, 'h0,   0, 0, 'h0,   0, 'h0,   1, 'h80,  0, 11, 7));
        vecs.push_back(mk(1, 'h140, 1, 'h140, 0, 1, 'h10,  0, 'h0,   0, 'h0,   1, 11, 7));
        vecs.push_back(mk(1, 'h100, 1, 'h300, 0, 0, 'h456, 0, 'h123, 0, 'h0,   0, 12, 8));
        vecs.push_back(mk(1, 'h140, 0, 'h0,   0, 0, 'h0,   0, 'h0,   1, 'h10,  0, 13, 8));
        vecs.push_back(mk(1, 'h204, 0, 'h0,   0, 0, 'h0,   0, 'h0,   1, 'h800, 0, 13, 8));
        vecs.push_back(mk(1, 'h300, 0, 'h0,   0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 13, 8));
        vecs.push_back(mk(1, 'h143, 0, 'h0,   0, 0, 'h0,   0, 'h0,   1, 'h10,  0, 13, 8));
        vecs.push_back(mk(0, 'h140, 1, 'h140, 0, 0, 'h0,   1, 'h10,  0, 'h0,   1, 13, 8));
        vecs.push_back(mk(0, 'h140, 1, 'h140, 0, 0, 'h0,   1, 'h10,  0, 'h0,   1, 13, 8));
        vecs.push_back(mk(0, 'h204, 1, 'h204, 1, 1, 'h900, 0, 'h0,   0, 'h0,   1, 13, 8));
        vecs.push_back(mk(1, 'h140, 0, 'h0,   0, 0, 'h0,   0, 'h0,   1, 'h10,  0, 13, 8));
        vecs.push_back(mk(1, 'h204, 0, 'h0,   0, 0, 'h0,   0, 'h0,   1, 'h800, 0, 13, 8));

        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en; pc_f = vecs[i].pc; upd_valid = vecs[i].uv;
            upd_pc = vecs[i].upc; upd_is_jump = vecs[i].uj; upd_taken = vecs[i].ut;
            upd_target = vecs[i].utgt; upd_pred_taken = vecs[i].upt;
            upd_pred_target = vecs[i].uptgt;
            @(negedge clk);
            check($sformatf("v%0d.pred_taken", i), {31'd0, pred_taken_f}, {31'd0, vecs[i].ept});
            check($sformatf("v%0d.pred_target", i), pred_target_f, vecs[i].etgt);
            check($sformatf("v%0d.mispredict", i), {31'd0, mispredict_e}, {31'd0, vecs[i].emis});
            check($sformatf("v%0d.branches", i), {24'd0, stat_branches}, {24'd0, vecs[i].ebr});
            check($sformatf("v%0d.mispredicts", i), {24'd0, stat_mispredicts}, {24'd0, vecs[i].emp});
            @(posedge clk); #1;
        end

        // Reset lands between edges while an allocating update is being presented
        enable = 1'b1; pc_f = 32'h140;
        upd_valid = 1'b1; upd_pc = 32'h140; upd_is_jump = 1'b0; upd_taken = 1'b1;
        upd_target = 32'h20; upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
        #1;
        check("pre_rst.pred_target", pred_target_f, 32'h10);
        #1 reset = 1'b0;
        #1;
        check("async_rst.pred_taken", {31'd0, pred_taken_f}, 32'd0);
        check("async_rst.pred_target", pred_target_f, 32'd0);
        check("async_rst.branches", {24'd0, stat_branches}, 32'd0);
        check("async_rst.mispredicts", {24'd0, stat_mispredicts}, 32'd0);
        check("async_rst.mispredict", {31'd0, mispredict_e}, 32'd1);
        @(posedge clk); #1;
        check("held_rst.pred_taken", {31'd0, pred_taken_f}, 32'd0);
        check("held_rst.branches", {24'd0, stat_branches}, 32'd0);
        upd_valid = 1'b0;
        @(negedge clk) reset = 1'b1;
        #1;
        check("post_rst.pred_taken", {31'd0, pred_taken_f}, 32'd0);

        // First edge after release trains: 5 updates, 2 mispredicts
        do_upd(32'h140, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0,  1'b1);
        do_upd(32'h140, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20, 1'b0);
        do_upd(32'h140, 1'b0, 1'b0, 32'h0,  1'b1, 32'h20, 1'b1);
        do_upd(32'h140, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20, 1'b0);
        do_upd(32'h140, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20, 1'b0);
        check("stat5.branches", {24'd0, stat_branches}, 32'd5);
        check("stat5.mispredicts", {24'd0, stat_mispredicts}, 32'd2);
        check("stat5.pred_taken", {31'd0, pred_taken_f}, 32'd1);
        check("stat5.pred_target", pred_target_f, 32'h20);

        // 251 more correctly-predicted not-taken updates wrap the 8-bit branch count to 0
        for (int k = 0; k < 251; k++)
            do_upd(32'h500, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("wrap.branches", {24'd0, stat_branches}, 32'd0);
        check("wrap.mispredicts", {24'd0, stat_mispredicts}, 32'd2);
        pc_f = 32'h500;
        #1;
        check("wrap.no_alloc", {31'd0, pred_taken_f}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
